rc4_key_search_ctrl: RTL and testbench

Top-level sequencer for the RC4 brute-force key search. For each candidate key it runs three stages in order: S-array init, then decrypt into decrypted memory, then the decrypted-message check. It samples the checker's verdict and then either stops with the key or advances to the next candidate. Key start and stride are parameters, so several instances can partition the key space; a stop input lets a sibling core halt this one.

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/stage_handshake.sv | 14 +
 rtl/rc4_key_search_ctrl.sv | 151 +++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and key-range constants for the RC4 brute-force key search.
package rc4_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StDecrypt,
    StCheck,
    StNext,
    StFound,
    StFail,
    StStopped
  } state_e;

  localparam int unsigned DEFAULT_KEY_WIDTH = 24;

  localparam logic [DEFAULT_KEY_WIDTH-1:0] KEY_MIN = 24'h000000;
  localparam logic [DEFAULT_KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF;

endpackage

// File: rtl/stage_handshake.sv
// Start/finish handshake for one pipeline stage.
// start follows the owning state, so it stays high until the stage reports finish.
module stage_handshake (
  input  logic active,
  input  logic finish,
  output logic start,
  output logic done
);

  assign start = active;
  // A finish seen while this stage is not active is a stray and is dropped here.
  assign done  = active & finish;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Per-core sequencer: walks candidate keys through init, decrypt and check,
// then reports found, exhausted or stopped.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = DEFAULT_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST = KEY_WIDTH'(KEY_MIN),
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(KEY_MAX),
  parameter int unsigned          KEY_STEP  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 stop,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 start_init,
  input  logic                 finish_init,
  output logic                 start_decrypt,
  input  logic                 finish_decrypt,
  output logic                 start_check,
  input  logic                 finish_check,
  input  logic                 key_valid,
  output logic                 found,
  output logic                 exhausted,
  output logic                 finish_search,
  output logic [KEY_WIDTH-1:0] attempts
);

  // One extra bit so a step past the top of the key space cannot wrap to a legal key.
  localparam logic [KEY_WIDTH:0] StepWide = (KEY_WIDTH + 1)'(KEY_STEP);
  localparam logic [KEY_WIDTH:0] LastWide = {1'b0, KEY_LAST};

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] attempts_q, attempts_d;
  logic                 stop_pend_q, stop_pend_d;

  logic                 init_done, decrypt_done, check_done;
  logic                 stop_req;
  logic [KEY_WIDTH:0]   key_next_wide;
  logic                 key_overrun;

  assign key_next_wide = {1'b0, key_q} + StepWide;
  assign key_overrun   = key_next_wide > LastWide;
  assign stop_req      = stop_pend_q | stop;

  stage_handshake u_init_hs (
    .active (state_q == StInit),
    .finish (finish_init),
    .start  (start_init),
    .done   (init_done)
  );

  stage_handshake u_decrypt_hs (
    .active (state_q == StDecrypt),
    .finish (finish_decrypt),
    .start  (start_decrypt),
    .done   (decrypt_done)
  );

  stage_handshake u_check_hs (
    .active (state_q == StCheck),
    .finish (finish_check),
    .start  (start_check),
    .done   (check_done)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    attempts_d  = attempts_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      StIdle, StFound, StFail, StStopped: begin
        if (go) begin
          state_d     = StInit;
          key_d       = KEY_FIRST;
          attempts_d  = '0;
          stop_pend_d = 1'b0;
        end
      end

      StInit: begin
        stop_pend_d = stop_req;
        if (init_done) begin
          state_d     = stop_req ? StStopped : StDecrypt;
          stop_pend_d = 1'b0;
        end
      end

      StDecrypt: begin
        stop_pend_d = stop_req;
        if (decrypt_done) begin
          state_d     = stop_req ? StStopped : StCheck;
          stop_pend_d = 1'b0;
        end
      end

      StCheck: begin
        stop_pend_d = stop_req;
        if (check_done) begin
          attempts_d  = attempts_q + KEY_WIDTH'(1);
          stop_pend_d = 1'b0;
          // A hit wins over a pending stop; a pending stop wins over running out of keys.
          if (key_valid) begin
            state_d = StFound;
          end else if (stop_req) begin
            state_d = StStopped;
          end else if (key_overrun) begin
            state_d = StFail;
          end else begin
            state_d = StNext;
          end
        end
      end

      StNext: begin
        if (stop) begin
          state_d = StStopped;
        end else begin
          key_d   = key_next_wide[KEY_WIDTH-1:0];
          state_d = StInit;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      key_q       <= KEY_FIRST;
      attempts_q  <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      attempts_q  <= attempts_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign secret_key    = key_q;
  assign attempts      = attempts_q;
  assign found         = (state_q == StFound);
  assign exhausted     = (state_q == StFail);
  assign finish_search = (state_q == StFound) | (state_q == StFail) | (state_q == StStopped);

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: four differently parameterised cores, a behavioural
// model per core compared every cycle, plus directed scenarios with literal results.
module tb_rc4_key_search_ctrl;

  localparam int N = 4;

  // Model phases
  localparam int PIdle = 0, PInit = 1, PDec = 2, PChk = 3, PNext = 4;
  localparam int PFound = 5, PFail = 6, PStop = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] go, stop, fin_i, fin_d, fin_c, kv;
  logic [N-1:0] s_init, s_dec, s_chk, found, exh, fsearch;
  logic [23:0]  key [N];
  logic [23:0]  att [N];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic logic [23:0] p_first(input int i);
    case (i)
      0, 1:    return 24'd0;
      2:       return 24'hFFFFFE;
      default: return 24'd5;
    endcase
  endfunction

  function automatic logic [23:0] p_last(input int i);
    case (i)
      0:       return 24'd2;
      1:       return 24'd3;
      2:       return 24'hFFFFFF;
      default: return 24'd40;
    endcase
  endfunction

  function automatic int p_step(input int i);
    case (i)
      0:       return 1;
      1, 2:    return 2;
      default: return 3;
    endcase
  endfunction

  rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_FIRST(24'd0), .KEY_LAST(24'd2), .KEY_STEP(1)) u_dut0 (
    .clk(clk), .reset(reset), .go(go[0]), .stop(stop[0]), .secret_key(key[0]),
    .start_init(s_init[0]), .finish_init(fin_i[0]), .start_decrypt(s_dec[0]),
    .finish_decrypt(fin_d[0]), .start_check(s_chk[0]), .finish_check(fin_c[0]),
    .key_valid(kv[0]), .found(found[0]), .exhausted(exh[0]), .finish_search(fsearch[0]),
    .attempts(att[0])
  );

  rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_FIRST(24'd0), .KEY_LAST(24'd3), .KEY_STEP(2)) u_dut1 (
    .clk(clk), .reset(reset), .go(go[1]), .stop(stop[1]), .secret_key(key[1]),
    .start_init(s_init[1]), .finish_init(fin_i[1]), .start_decrypt(s_dec[1]),
    .finish_decrypt(fin_d[1]), .start_check(s_chk[1]), .finish_check(fin_c[1]),
    .key_valid(kv[1]), .found(found[1]), .exhausted(exh[1]), .finish_search(fsearch[1]),
    .attempts(att[1])
  );

  rc4_key_search_ctrl #(
    .KEY_WIDTH(24), .KEY_FIRST(24'hFFFFFE), .KEY_LAST(24'hFFFFFF), .KEY_STEP(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .go(go[2]), .stop(stop[2]), .secret_key(key[2]),
    .start_init(s_init[2]), .finish_init(fin_i[2]), .start_decrypt(s_dec[2]),
    .finish_decrypt(fin_d[2]), .start_check(s_chk[2]), .finish_check(fin_c[2]),
    .key_valid(kv[2]), .found(found[2]), .exhausted(exh[2]), .finish_search(fsearch[2]),
    .attempts(att[2])
  );

  rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_FIRST(24'd5), .KEY_LAST(24'd40), .KEY_STEP(3)) u_dut3 (
    .clk(clk), .reset(reset), .go(go[3]), .stop(stop[3]), .secret_key(key[3]),
    .start_init(s_init[3]), .finish_init(fin_i[3]), .start_decrypt(s_dec[3]),
    .finish_decrypt(fin_d[3]), .start_check(s_chk[3]), .finish_check(fin_c[3]),
    .key_valid(kv[3]), .found(found[3]), .exhausted(exh[3]), .finish_search(fsearch[3]),
    .attempts(att[3])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ph   [N];
  logic [23:0] m_key  [N];
  logic [23:0] m_att  [N];
  bit          m_pend [N];

  task automatic model_step(input int i);
    bit sp;
    bit fin;
    sp = m_pend[i] | stop[i];
    if (reset) begin
      m_ph[i] = PIdle; m_key[i] = p_first(i); m_att[i] = 24'd0; m_pend[i] = 1'b0;
      return;
    end
    case (m_ph[i])
      PIdle, PFound, PFail, PStop: begin
        if (go[i]) begin
          m_ph[i] = PInit; m_key[i] = p_first(i); m_att[i] = 24'd0; m_pend[i] = 1'b0;
        end
      end
      PInit, PDec: begin
        fin = (m_ph[i] == PInit) ? fin_i[i] : fin_d[i];
        if (fin) begin
          m_ph[i] = sp ? PStop : m_ph[i] + 1;
          m_pend[i] = 1'b0;
        end else begin
          m_pend[i] = sp;
        end
      end
      PChk: begin
        if (fin_c[i]) begin
          m_att[i] = m_att[i] + 24'd1;
          m_pend[i] = 1'b0;
          if (kv[i]) m_ph[i] = PFound;
          else if (sp) m_ph[i] = PStop;
          else if (longint'(m_key[i]) + longint'(p_step(i)) > longint'(p_last(i))) m_ph[i] = PFail;
          else m_ph[i] = PNext;
        end else begin
          m_pend[i] = sp;
        end
      end
      PNext: begin
        if (stop[i]) begin
          m_ph[i] = PStop;
        end else begin
          m_key[i] = m_key[i] + 24'(p_step(i));
          m_ph[i] = PInit;
        end
      end
      default: m_ph[i] = PIdle;
    endcase
  endtask

  function automatic logic [63:0] exp_vec(input int i);
    return 64'({m_ph[i] == PInit, m_ph[i] == PDec, m_ph[i] == PChk, m_ph[i] == PFound,
                m_ph[i] == PFail, m_ph[i] >= PFound, m_key[i], m_att[i]});
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      m_ph[i] = PIdle; m_key[i] = p_first(i); m_att[i] = 24'd0; m_pend[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) model_step(i);
      chk_en = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          check($sformatf("cycle_dut%0d", i),
                64'({s_init[i], s_dec[i], s_chk[i], found[i], exh[i], fsearch[i], key[i], att[i]}),
                exp_vec(i));
        end
      end
    end
  end

  // ---------------- stage responders ----------------
  int          lat [N][3];
  int          cnt [N][3];
  bit          tied [N];
  bit          noise [N];
  bit          rnd_lat [N];
  logic [23:0] target [N];

  initial begin
    logic [2:0] act;
    logic [2:0] f;
    fin_i = '0; fin_d = '0; fin_c = '0; kv = '0;
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 3; s++) begin lat[i][s] = 3; cnt[i][s] = 0; end
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        act = {s_chk[i], s_dec[i], s_init[i]};
        for (int s = 0; s < 3; s++) begin
          if (act[s] === 1'b1) begin
            if (cnt[i][s] == 0) lat[i][s] = rnd_lat[i] ? int'($urandom_range(1, 4)) : 3;
            cnt[i][s]++;
            f[s] = tied[i] || (cnt[i][s] == lat[i][s]);
          end else begin
            cnt[i][s] = 0;
            f[s] = tied[i] || (noise[i] && $urandom_range(0, 3) == 0);
          end
        end
        fin_i[i] = f[0];
        fin_d[i] = f[1];
        fin_c[i] = f[2];
        if (s_chk[i] === 1'b1) kv[i] = (key[i] == target[i]);
        else kv[i] = noise[i] ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Start-edge log for core 0: {stage, key}
  logic [25:0] log0 [$];
  logic [2:0]  prev0 = 3'b000;
  initial begin
    forever begin
      @(negedge clk);
      if (s_init[0] === 1'b1 && !prev0[0]) log0.push_back({2'd1, key[0]});
      if (s_dec[0] === 1'b1 && !prev0[1]) log0.push_back({2'd2, key[0]});
      if (s_chk[0] === 1'b1 && !prev0[2]) log0.push_back({2'd3, key[0]});
      prev0 = {s_chk[0] === 1'b1, s_dec[0] === 1'b1, s_init[0] === 1'b1};
    end
  end

  task automatic pulse_go(input int i);
    @(negedge clk);
    go[i] = 1'b1;
    @(negedge clk);
    go[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (fsearch[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_dut%0d", i), 64'(fsearch[i]), 64'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int c3;
    go = '0;
    stop = '0;
    for (int i = 0; i < N; i++) begin
      tied[i] = 1'b0; noise[i] = 1'b0; rnd_lat[i] = 1'b0; target[i] = 24'hFFFFFF;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_key0", 64'(key[0]), 64'd0);
    check("rst_key2", 64'(key[2]), 64'hFFFFFE);
    check("rst_key3", 64'(key[3]), 64'd5);
    check("rst_att0", 64'(att[0]), 64'd0);
    check("rst_status", 64'({fsearch, found, exh, s_init, s_dec, s_chk}), 64'd0);

    // Key 2 is the valid one; a go mid-run must be ignored
    target[0] = 24'd2;
    log0.delete();
    pulse_go(0);
    repeat (5) @(negedge clk);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    wait_done(0, 200);
    check("t1_found", 64'(found[0]), 64'd1);
    check("t1_key", 64'(key[0]), 64'd2);
    check("t1_att", 64'(att[0]), 64'd3);
    check("t1_log_len", 64'(log0.size()), 64'd9);
    for (int k = 0; k < 9 && k < log0.size(); k++) begin
      check($sformatf("t1_log%0d", k), 64'(log0[k]), 64'({2'(k % 3 + 1), 24'(k / 3)}));
    end

    // All finishes tied high: 4 cycles per key, exhausted in cycle 12
    tied[0] = 1'b1;
    target[0] = 24'hFFFFFF;
    @(negedge clk);
    go[0] = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      go[0] = 1'b0;
      n++;
    end while (exh[0] !== 1'b1 && n < 40);
    check("t3_cycles", 64'(n), 64'd12);
    check("t3_att", 64'(att[0]), 64'd3);
    check("t3_key", 64'(key[0]), 64'd2);

    // Stop during decrypt of key 1
    tied[0] = 1'b0;
    @(negedge clk);
    log0.delete();
    pulse_go(0);
    n = 0;
    while (!(s_dec[0] === 1'b1 && key[0] == 24'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    wait_done(0, 100);
    check("t4_found", 64'(found[0]), 64'd0);
    check("t4_exh", 64'(exh[0]), 64'd0);
    check("t4_att", 64'(att[0]), 64'd1);
    check("t4_key", 64'(key[0]), 64'd1);
    c3 = 0;
    foreach (log0[k]) if (log0[k] == {2'd3, 24'd1}) c3++;
    check("t4_no_check_key1", 64'(c3), 64'd0);
    check("t4_last_start", 64'(log0[$]), 64'({2'd2, 24'd1}));

    // Hit and stop in the same cycle: found wins
    tied[0] = 1'b1;
    target[0] = 24'd0;
    pulse_go(0);
    n = 0;
    while (s_chk[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    check("t5_found", 64'(found[0]), 64'd1);
    check("t5_att", 64'(att[0]), 64'd1);
    check("t5_key", 64'(key[0]), 64'd0);

    // Reset in the middle of checking key 1
    tied[0] = 1'b0;
    target[0] = 24'hFFFFFF;
    pulse_go(0);
    n = 0;
    while (!(s_chk[0] === 1'b1 && key[0] == 24'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_flags", 64'({s_init[0], s_dec[0], s_chk[0], found[0], exh[0], fsearch[0]}), 64'd0);
    check("t6_key", 64'(key[0]), 64'd0);
    check("t6_att", 64'(att[0]), 64'd0);

    // Stride 2 up to 3: keys 0 and 2
    pulse_go(1);
    wait_done(1, 200);
    check("t2_exh", 64'(exh[1]), 64'd1);
    check("t2_att", 64'(att[1]), 64'd2);
    check("t2_key", 64'(key[1]), 64'd2);

    // Top of key space: FFFFFE + 2 must not wrap to a legal key
    pulse_go(2);
    wait_done(2, 100);
    check("t2b_exh", 64'(exh[2]), 64'd1);
    check("t2b_att", 64'(att[2]), 64'd1);
    check("t2b_key", 64'(key[2]), 64'hFFFFFE);

    // Randomised runs on core 3
    noise[3] = 1'b1;
    rnd_lat[3] = 1'b1;
    for (int r = 0; r < 25; r++) begin
      tied[3] = ($urandom_range(0, 4) == 0);
      target[3] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'(5 + 3 * $urandom_range(0, 11));
      pulse_go(3);
      n = 0;
      while (fsearch[3] !== 1'b1 && n < 600) begin
        stop[3] = ($urandom_range(0, 79) == 0);
        go[3] = ($urandom_range(0, 49) == 0);
        @(negedge clk);
        n++;
      end
      stop[3] = 1'b0;
      go[3] = 1'b0;
      check($sformatf("rand_done%0d", r), 64'(fsearch[3]), 64'd1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
